rrat: RTL and testbench

Retirement register alias table: holds the committed architectural-to-physical register mapping, updated by up to NSIZE in-order ROB commits per cycle. Each commit that overwrites a mapping returns the displaced physical register to the free list through its `din`/`enqueue` ports. On `rob_flush`, the table supplies the committed mapping image so the front-end RAT can be restored. It sits between the ROB commit port and the free list's enqueue side.

---
 rtl/rv32i_types.sv | 11 +
 rtl/rrat_fwd.sv | 46 ++++
 rtl/rrat.sv | 101 ++++++++++
 tb/tb_rrat.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// Shared RV32I core types used by the retirement alias table.
package rv32i_types;

    localparam int unsigned ARCH_REGS      = 32;
    localparam int unsigned AREG_BITS      = 5;
    localparam int unsigned PREG_BITS_DFLT = 6;

    typedef logic [PREG_BITS_DFLT-1:0] preg_t;
    typedef logic [AREG_BITS-1:0]      areg_t;

endpackage

// File: rtl/rrat_fwd.sv
// Same-group forwarding for the retirement alias table: computes the
// displaced register per lane and the youngest-lane write per table entry.
module rrat_fwd
    import rv32i_types::*;
#(
    parameter int unsigned PREG_BITS = 6,
    parameter int unsigned NSIZE     = 1
) (
    input  logic [PREG_BITS-1:0] tbl_i       [ARCH_REGS],
    input  logic [NSIZE-1:0]     valid_i,
    input  areg_t                rd_i        [NSIZE],
    input  logic [PREG_BITS-1:0] phys_i      [NSIZE],
    output logic [PREG_BITS-1:0] free_preg_o [NSIZE],
    output logic [NSIZE-1:0]     live_o,
    output logic [ARCH_REGS-1:1] wr_en_o,
    output logic [PREG_BITS-1:0] wr_data_o   [1:ARCH_REGS-1]
);

    // Per-lane old mapping, forwarding the nearest older lane with the same rd
    always_comb begin
        for (int unsigned i = 0; i < NSIZE; i++) begin
            live_o[i]      = valid_i[i] && (rd_i[i] != '0);
            free_preg_o[i] = tbl_i[rd_i[i]];
            for (int unsigned j = 0; j < i; j++) begin
                if (valid_i[j] && (rd_i[j] != '0) && (rd_i[j] == rd_i[i])) begin
                    free_preg_o[i] = phys_i[j];
                end
            end
        end
    end

    // Per-entry write enable; later (younger) lanes override older ones
    always_comb begin
        for (int unsigned e = 1; e < ARCH_REGS; e++) begin
            wr_en_o[e]   = 1'b0;
            wr_data_o[e] = '0;
            for (int unsigned i = 0; i < NSIZE; i++) begin
                if (live_o[i] && (rd_i[i] == AREG_BITS'(e))) begin
                    wr_en_o[e]   = 1'b1;
                    wr_data_o[e] = phys_i[i];
                end
            end
        end
    end

endmodule

// File: rtl/rrat.sv
// Retirement register alias table: committed arch->phys mapping, frees
// displaced registers and supplies the restore image on flush.
// Optional performance counters are enabled with `define RRAT_PERF_EN.
module rrat
    import rv32i_types::*;
#(
    parameter int unsigned PREG_BITS = 6,
    parameter int unsigned NSIZE     = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NSIZE-1:0]     commit_valid,
    input  areg_t                commit_rd_arch [NSIZE],
    input  logic [PREG_BITS-1:0] commit_rd_phys [NSIZE],
    input  logic                 rob_flush,
    output logic [PREG_BITS-1:0] free_preg      [NSIZE],
    output logic [NSIZE-1:0]     free_valid,
    output logic [PREG_BITS-1:0] restore_map    [ARCH_REGS],
    output logic [31:0]          perf_commits,
    output logic [31:0]          perf_frees
);

    logic [PREG_BITS-1:0] tbl_q    [1:ARCH_REGS-1];
    logic [PREG_BITS-1:0] tbl_d    [1:ARCH_REGS-1];
    logic [PREG_BITS-1:0] tbl_view [ARCH_REGS];
    logic [NSIZE-1:0]     live;
    logic [ARCH_REGS-1:1] wr_en;
    logic [PREG_BITS-1:0] wr_data  [1:ARCH_REGS-1];

    // Table image with x0 hardwired to zero
    always_comb begin
        tbl_view[0] = '0;
        for (int unsigned e = 1; e < ARCH_REGS; e++) begin
            tbl_view[e] = tbl_q[e];
        end
    end

    rrat_fwd #(
        .PREG_BITS (PREG_BITS),
        .NSIZE     (NSIZE)
    ) u_fwd (
        .tbl_i       (tbl_view),
        .valid_i     (commit_valid),
        .rd_i        (commit_rd_arch),
        .phys_i      (commit_rd_phys),
        .free_preg_o (free_preg),
        .live_o      (live),
        .wr_en_o     (wr_en),
        .wr_data_o   (wr_data)
    );

    // Free list ignores enqueues while it refills on flush
    always_comb begin
        free_valid = live & ~{NSIZE{rob_flush}};
    end

    // Next table state; also the same-cycle restore image
    always_comb begin
        restore_map[0] = '0;
        for (int unsigned e = 1; e < ARCH_REGS; e++) begin
            tbl_d[e]       = wr_en[e] ? wr_data[e] : tbl_q[e];
            restore_map[e] = tbl_d[e];
        end
    end

    // Table flops, identity mapping on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned e = 1; e < ARCH_REGS; e++) begin
                tbl_q[e] <= PREG_BITS'(e);
            end
        end else begin
            for (int unsigned e = 1; e < ARCH_REGS; e++) begin
                tbl_q[e] <= tbl_d[e];
            end
        end
    end

`ifdef RRAT_PERF_EN
    logic [31:0] perf_commits_q;
    logic [31:0] perf_frees_q;

    // Wrapping commit and free counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_commits_q <= '0;
            perf_frees_q   <= '0;
        end else begin
            perf_commits_q <= perf_commits_q + 32'($countones(commit_valid));
            perf_frees_q   <= perf_frees_q + 32'($countones(free_valid));
        end
    end

    assign perf_commits = perf_commits_q;
    assign perf_frees   = perf_frees_q;
`else
    assign perf_commits = '0;
    assign perf_frees   = '0;
`endif

endmodule

// File: tb/tb_rrat.sv
// Directed bench for rrat with two commit lanes.
module tb_rrat;

    localparam int unsigned PB = 6;
    localparam int unsigned NS = 2;
`ifdef RRAT_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [NS-1:0] commit_valid;
    logic [4:0]    commit_rd_arch [NS];
    logic [PB-1:0] commit_rd_phys [NS];
    logic          rob_flush;
    logic [PB-1:0] free_preg      [NS];
    logic [NS-1:0] free_valid;
    logic [PB-1:0] restore_map    [32];
    logic [31:0]   perf_commits;
    logic [31:0]   perf_frees;

    int total = 0;
    int bad   = 0;
    int exp_commits = 0;
    int exp_frees   = 0;

    always #5 clk = ~clk;

    rrat #(.PREG_BITS(PB), .NSIZE(NS)) dut (
        .clk            (clk),
        .rst            (rst),
        .commit_valid   (commit_valid),
        .commit_rd_arch (commit_rd_arch),
        .commit_rd_phys (commit_rd_phys),
        .rob_flush      (rob_flush),
        .free_preg      (free_preg),
        .free_valid     (free_valid),
        .restore_map    (restore_map),
        .perf_commits   (perf_commits),
        .perf_frees     (perf_frees)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Apply inputs just after a falling edge, then settle
    task automatic drive(input logic [NS-1:0] cv, input logic [4:0] r0, input logic [PB-1:0] p0,
                         input logic [4:0] r1, input logic [PB-1:0] p1, input logic fl);
        @(negedge clk);
        commit_valid      = cv;
        commit_rd_arch[0] = r0;
        commit_rd_phys[0] = p0;
        commit_rd_arch[1] = r1;
        commit_rd_phys[1] = p1;
        rob_flush         = fl;
        #1;
    endtask

    // Clock the applied inputs in and account expected perf increments
    task automatic tick(input int nc, input int nf);
        @(posedge clk);
        exp_commits += nc;
        exp_frees   += nf;
    endtask

    task automatic idle();
        drive(2'b00, 5'd0, '0, 5'd0, '0, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        commit_valid = '0;
        commit_rd_arch[0] = '0; commit_rd_arch[1] = '0;
        commit_rd_phys[0] = '0; commit_rd_phys[1] = '0;
        rob_flush = 1'b0;
        #12;
        chk("rst_map5_during", 32'(restore_map[5]), 32'd5);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_map5", 32'(restore_map[5]), 32'd5);
        chk("rst_map0", 32'(restore_map[0]), 32'd0);
        chk("rst_map31", 32'(restore_map[31]), 32'd31);
        chk("rst_fv", 32'(free_valid), 32'd0);
        chk("rst_pc", perf_commits, 32'd0);
        chk("rst_pf", perf_frees, 32'd0);

        // single commit rd5 -> 40
        drive(2'b01, 5'd5, 6'd40, 5'd0, '0, 1'b0);
        chk("single_fp0", 32'(free_preg[0]), 32'd5);
        chk("single_fv", 32'(free_valid), 32'b01);
        chk("single_map_same", 32'(restore_map[5]), 32'd40);
        tick(1, 1);
        idle();
        chk("single_map_next", 32'(restore_map[5]), 32'd40);
        chk("idle_fv", 32'(free_valid), 32'd0);

        // x0 commit
        drive(2'b01, 5'd0, 6'd41, 5'd0, '0, 1'b0);
        chk("x0_fv", 32'(free_valid), 32'd0);
        chk("x0_map0", 32'(restore_map[0]), 32'd0);
        tick(1, 0);
        idle();
        chk("x0_map0_next", 32'(restore_map[0]), 32'd0);
        chk("x0_pc", perf_commits, PERF ? 32'(exp_commits) : 32'd0);
        chk("x0_pf", perf_frees, PERF ? 32'(exp_frees) : 32'd0);

        // same-group conflict on rd7
        drive(2'b11, 5'd7, 6'd33, 5'd7, 6'd34, 1'b0);
        chk("conf_fp0", 32'(free_preg[0]), 32'd7);
        chk("conf_fp1", 32'(free_preg[1]), 32'd33);
        chk("conf_fv", 32'(free_valid), 32'b11);
        chk("conf_map_same", 32'(restore_map[7]), 32'd34);
        tick(2, 2);
        idle();
        chk("conf_map_next", 32'(restore_map[7]), 32'd34);

        // distinct rds in one group read the table independently
        drive(2'b11, 5'd5, 6'd20, 5'd6, 6'd21, 1'b0);
        chk("dual_fp0", 32'(free_preg[0]), 32'd40);
        chk("dual_fp1", 32'(free_preg[1]), 32'd6);
        tick(2, 2);

        // lane1 only, lane0 invalid with same rd must not forward
        drive(2'b10, 5'd5, 6'd60, 5'd5, 6'd22, 1'b0);
        chk("l1only_fp1", 32'(free_preg[1]), 32'd20);
        chk("l1only_fv", 32'(free_valid), 32'b10);
        tick(1, 1);

        // flush with commit rd3 -> 50
        drive(2'b01, 5'd3, 6'd50, 5'd0, '0, 1'b1);
        chk("flush_fv", 32'(free_valid), 32'd0);
        chk("flush_map3_same", 32'(restore_map[3]), 32'd50);
        tick(1, 0);
        idle();
        chk("flush_map3_next", 32'(restore_map[3]), 32'd50);

        // next commit to rd3 frees the value written during flush
        drive(2'b01, 5'd3, 6'd51, 5'd0, '0, 1'b0);
        chk("postflush_fp0", 32'(free_preg[0]), 32'd50);
        tick(1, 1);
        idle();
        chk("map5_final", 32'(restore_map[5]), 32'd22);
        chk("pc_before_rst", perf_commits, PERF ? 32'(exp_commits) : 32'd0);
        chk("pf_before_rst", perf_frees, PERF ? 32'(exp_frees) : 32'd0);

        // asynchronous reset between clock edges
        #2;
        rst = 1'b1;
        #1;
        chk("arst_map5", 32'(restore_map[5]), 32'd5);
        chk("arst_map7", 32'(restore_map[7]), 32'd7);
        chk("arst_map3", 32'(restore_map[3]), 32'd3);
        chk("arst_pc", perf_commits, 32'd0);
        chk("arst_pf", perf_frees, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("arst_map6_after", 32'(restore_map[6]), 32'd6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
